// File: rtl/oka_233bit_seq.sv
// 233-bit GF(2)[x] carry-less multiplier: one 117-bit core, time-multiplexed over even/odd/sum operand halves.
// Latency: accept at edge T, out_valid from cycle T+4; minimum initiation interval 5 cycles.
// Backpressure: y and out_valid hold in DONE until out_ready; in_ready is low from accept until the product is taken.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready with operands a, b (bit i = coeff of x^i);
//        out_valid/out_ready with product y (2n-1 bits); op_count (32-bit completed-product counter)
//        exists only when OKA_SEQ_CNT_EN is defined.
module oka_233bit_seq #(
    parameter int N = 233
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-2:0]   y
`ifdef OKA_SEQ_CNT_EN
    ,
    output logic [31:0]      op_count
`endif
);

    localparam int H  = (N + 1) / 2;   // half-operand width (117)
    localparam int PW = 2 * H - 1;     // core product width (233)
    localparam int SW = 2 * PW - 1;    // spread product width (465)

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    op_a, op_b;
    logic [PW-1:0]   p0, p1;
    logic [H-1:0]    core_x, core_z;
    logic [PW-1:0]   core_p;
    logic [SW-1:0]   y_full;

    function automatic logic [H-1:0] even_bits(input logic [N-1:0] v);
        logic [H-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++) r[i] = v[2*i];
        return r;
    endfunction

    // Odd half is one bit short of H; its MSB stays zero.
    function automatic logic [H-1:0] odd_bits(input logic [N-1:0] v);
        logic [H-1:0] r;
        r = '0;
        for (int i = 0; i < N / 2; i++) r[i] = v[2*i+1];
        return r;
    endfunction

    // The combinational 117x117 carry-less core.
    function automatic logic [PW-1:0] core_mul(input logic [H-1:0] x, input logic [H-1:0] z);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++)
            if (x[i]) r = r ^ (PW'(z) << i);
        return r;
    endfunction

    // Substituting x -> x^2: coefficient i moves to position 2i.
    function automatic logic [SW-1:0] spread(input logic [PW-1:0] p);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < PW; i++) r[2*i] = p[i];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, handshake outputs and the single core-input multiplexer.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_x    = '0;
        core_z    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL0;
            end
            MUL0: begin
                core_x    = even_bits(op_a);
                core_z    = even_bits(op_b);
                state_nxt = MUL1;
            end
            MUL1: begin
                core_x    = odd_bits(op_a);
                core_z    = odd_bits(op_b);
                state_nxt = MUL2;
            end
            MUL2: begin
                core_x    = even_bits(op_a) ^ odd_bits(op_a);
                core_z    = even_bits(op_b) ^ odd_bits(op_b);
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign core_p = core_mul(core_x, core_z);

    // a = ae(x^2) + x*ao(x^2): middle term (ae_a*ao_b + ao_a*ae_b) = P2 ^ P0 ^ P1.
    // Bits shifted beyond SW are always zero, so truncation loses nothing.
    assign y_full = spread(p0) ^ (spread(p1) << 2) ^ (spread(p0 ^ p1 ^ core_p) << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            p0   <= '0;
            p1   <= '0;
            y    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a <= a;
                    op_b <= b;
                end
                MUL0:    p0 <= core_p;
                MUL1:    p1 <= core_p;
                MUL2:    y  <= y_full[2*N-2:0];
                default: ;
            endcase
        end
    end

`ifdef OKA_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                         op_count <= '0;
        else if (out_valid && out_ready) op_count <= op_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_oka_233bit_seq.sv
// Directed and random checks of the sequential 233-bit carry-less multiplier.
// Stimulus changes 1 time unit after the rising edge; outputs are sampled there too.
// Optional counter checks compile only when OKA_SEQ_CNT_EN is defined.
module tb_oka_233bit_seq;

    localparam int N  = 233;
    localparam int YW = 2 * N - 1;
    localparam int NUM_RAND = 10000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] y;
`ifdef OKA_SEQ_CNT_EN
    logic [31:0]   op_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    oka_233bit_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef OKA_SEQ_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [YW-1:0] clmul_ref(input logic [N-1:0] x, input logic [N-1:0] z);
        logic [YW-1:0] r;
        logic [YW-1:0] t;
        r = '0;
        t = '0;
        t[N-1:0] = x;
        for (int i = 0; i < N; i++)
            if (z[i]) r = r ^ (t << i);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
        return t[N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one operand pair and returns once out_valid is seen (or the budget runs out).
    // lat = cycles from the accept edge to the first cycle with out_valid; 99 on timeout.
    task automatic do_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic ordy,
                         output logic [YW-1:0] y_got, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        a         = xa;
        b         = xb;
        in_valid  = 1'b1;
        out_ready = ordy;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = 99;
        y_got = y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (y !== '0) begin n_fail++; $display("FAIL reset_y got=%h exp=0", y); end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        logic [YW-1:0] yg;
        logic [YW-1:0] exp;
        logic [N-1:0]  ones;
        int lat;
        do_op(N'(1), N'(1), 1'b1, yg, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL ident_latency got=%0d exp=4", lat); end
        n_checks++;
        if (yg !== YW'(1)) begin n_fail++; $display("FAIL ident_y got=%h exp=1", yg); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL ident_ready_t5 got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
        ones = '1;
        do_op(ones, N'(1), 1'b1, yg, lat);
        exp = '0;
        exp[N-1:0] = ones;
        n_checks++;
        if (yg !== exp) begin n_fail++; $display("FAIL ones_times_1 got=%h exp=%h", yg, exp); end
        tick();
    endtask

    task automatic test_top_bits();
        logic [YW-1:0] yg;
        logic [YW-1:0] exp;
        logic [N-1:0]  t;
        int lat;
        t = '0;
        t[N-1] = 1'b1;
        do_op(t, t, 1'b1, yg, lat);
        exp = '0;
        exp[YW-1] = 1'b1;
        n_checks++;
        if (yg !== exp) begin n_fail++; $display("FAIL top_bit got=%h exp=%h", yg, exp); end
        tick();
        do_op(N'(3), N'(3), 1'b1, yg, lat);
        n_checks++;
        if (yg !== YW'(5)) begin n_fail++; $display("FAIL three_sq got=%h exp=5", yg); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [YW-1:0] yg;
        logic [YW-1:0] exp;
        logic [N-1:0]  xa, xb;
        int lat;
        int bad;
        xa = rand_op();
        xb = rand_op();
        exp = clmul_ref(xa, xb);
        do_op(xa, xb, 1'b0, yg, lat);
        n_checks++;
        if (yg !== exp || lat !== 4) begin n_fail++; $display("FAIL bp_first got=%h lat=%0d exp=%h lat=4", yg, lat, exp); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = rand_op();
            b = rand_op();
            tick();
            n_checks++;
            if (y !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got y=%h ir=%b ov=%b exp y=%h ir=0 ov=1", i, y, in_ready, out_valid, exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || y !== exp)
            begin n_fail++; $display("FAIL bp_no_restart got ir=%b y=%h exp ir=1 y=%h", in_ready, y, exp); end
    endtask

    task automatic test_reset_mid();
        logic [YW-1:0] yg;
        int lat;
        int seen;
        a = rand_op();
        b = rand_op();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();              // accept edge T, now in MUL0
        in_valid = 1'b0;
        tick();              // MUL1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL rst_mid got ov=%b y=%h ir=%b exp ov=0 y=0 ir=1", out_valid, y, in_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_emit got=%0d exp=0", seen); end
        do_op(N'(5), N'(7), 1'b1, yg, lat);
        n_checks++;
        if (yg !== YW'(8'h1B) || lat !== 4)
            begin n_fail++; $display("FAIL rst_mid_next got=%h lat=%0d exp=1b lat=4", yg, lat); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [YW-1:0] expq[$];
        logic [YW-1:0] e;
        int sent, recv, cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        a = rand_op();
        b = rand_op();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (recv < NUM_RAND && cyc < 90000) begin
            logic acc;
            acc = in_valid && in_ready;
            if (acc) begin
                expq.push_back(clmul_ref(a, b));
                sent++;
            end
            if (out_valid && out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : 'x;
                n_checks++;
                if (y !== e) begin
                    n_fail++;
                    $display("FAIL rand_y idx=%0d got=%h exp=%h", recv, y, e);
                end
                recv++;
            end
            tick();
            cyc++;
            if (acc) begin
                a = rand_op();
                b = rand_op();
                in_valid = (sent < NUM_RAND);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv !== NUM_RAND || sent !== NUM_RAND)
            begin n_fail++; $display("FAIL rand_count got in=%0d out=%0d exp=%0d", sent, recv, NUM_RAND); end
        tick();
        tick();
    endtask

`ifdef OKA_SEQ_CNT_EN
    task automatic test_count();
        logic [YW-1:0] yg;
        int lat;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            do_op(rand_op(), rand_op(), 1'b1, yg, lat);
            tick();
        end
        n_checks++;
        if (op_count !== 32'd3) begin n_fail++; $display("FAIL cnt_three got=%0d exp=3", op_count); end
        force dut.op_count = 32'hFFFF_FFFF;
        #1;
        release dut.op_count;
        do_op(N'(1), N'(1), 1'b1, yg, lat);
        tick();
        n_checks++;
        if (op_count !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap got=%h exp=0", op_count); end
        do_op(N'(1), N'(1), 1'b1, yg, lat);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (op_count !== 32'd0) begin n_fail++; $display("FAIL cnt_rst got=%h exp=0", op_count); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_identity();
        test_top_bits();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef OKA_SEQ_CNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oka_233bit_seq.md
# oka_233bit_seq

Sequential controller that computes the 233-bit GF(2)[x] carry-less product by time-multiplexing a single combinational `OKA_117bit` core over three cycles. It performs the same even/odd split and overlap-free recombination as the fully parallel 233-bit multiplier, using one third of the core area. A valid/ready handshake at both ports lets it sit between an operand source (e.g. an ECC point-arithmetic sequencer) and the downstream field reduction.

## Interface
- `n`, 233: operand width in bits; the block is verified only at 233.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair presented.
- `in_ready`  out  1  block can accept operands.
- `a`, `b`  in  n  operands; bit i is the coefficient of x^i.
- `out_valid`  out  1  product available.
- `out_ready`  in  1  consumer accepts the product.
- `y`  out  2n-1  carry-less product a·b.
- `op_count`  out  32  completed-product counter; present only under `OKA_SEQ_CNT_EN`.

## Operation
- Operand split: ae = even bits of the operand, 117 bits (bits 0,2,…,232); ao = odd bits, zero-extended to 117 bits (bits 1,3,…,231 with MSB 0).
- States: IDLE → MUL0 → MUL1 → MUL2 → DONE → IDLE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch a and b into operand registers and go to MUL0.
- MUL0: core inputs are ae(a), ae(b). Register the 233-bit result as P0.
- MUL1: core inputs are ao(a), ao(b). Register the result as P1.
- MUL2: core inputs are ae(a)^ao(a) and ae(b)^ao(b); the result is P2 (not stored). Compute and register `y` = S(P0) ^ (S(P1)<<2) ^ (S(P0^P1^P2)<<1), where S maps bit i to bit 2i (465 bits). Truncate to 2n-1 bits; the truncated bits are guaranteed zero.
- DONE: `out_valid`=1. `y` is held stable until `out_valid`&`out_ready`, then go to IDLE.
- Inputs `a`/`b`/`in_valid` are ignored outside IDLE. `out_ready` is ignored outside DONE.
- A single core multiplexer, driven by the state, selects the core inputs. Outside MUL0–MUL2 the core inputs are zero.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `y`=0, P0=P1=0, operand registers=0, `op_count`=0.
- Accept handshake at edge T. MUL0 runs in cycle T+1, MUL1 in T+2, MUL2 in T+3. `out_valid`=1 from cycle T+4.
- With `out_ready` held at 1, `out_valid` lasts one cycle and `in_ready`=1 at T+5. Minimum initiation interval is 5 cycles.
- Backpressure: `out_valid` and `y` stay constant for any number of cycles with `out_ready`=0.
- `in_ready` and `out_valid` are never high in the same cycle.
- `rst` asserted in any state, including mid-MUL: the next edge restores all reset values. The in-flight product is discarded and nothing is emitted.
- `rst` takes priority over a simultaneous handshake.
- The core is combinational. The critical path is the operand register, through the core and recombination XORs, to P0/P1/`y`.

## Configuration
- `OKA_SEQ_CNT_EN` defined: the 32-bit `op_count` port exists. It increments on each `out_valid`&`out_ready`, wraps from 0xFFFFFFFF to 0, and is cleared by `rst`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Identity: a=1, b=1. Handshake at T → `y`=1 with `out_valid` rising at T+4 exactly. Then a=all-ones, b=1 → `y`=a zero-extended.
- Top bits: a=b=x^232 → `y` has only bit 464 set. a=3, b=3 → `y`=5, showing no carries (GF(2) arithmetic).
- Backpressure: random a, b with `out_ready`=0 for 10 cycles after `out_valid`. Required: `y` stable, `in_ready`=0, and `in_valid` pulses ignored. Releasing `out_ready` gives `in_ready`=1 on the next cycle.
- Reset mid-operation: assert `rst` during MUL1. Required: next cycle `out_valid`=0, `y`=0, `in_ready`=1. A following operation a=0x5, b=0x7 gives `y`=0x1B.
- Random regression: 10,000 back-to-back random pairs with random `out_ready` stalls. Each `y` must match a bit-serial carry-less reference model, and the output count must equal the input count.
- With `OKA_SEQ_CNT_EN`: 3 completed products → `op_count`=3. Preload 0xFFFFFFFF via force, complete one → 0. `rst` → 0.
